srf_stream_sequencer: RTL and testbench
=======================================

// Module: srf_stream_sequencer
// PURPOSE
//  Initiator side of the streaming register file (SRF) port. Accepts a vector-op command
//  (two source streams, one destination stream, iteration count) and sequences SRF reads,
//  operand handoff to a vector functional unit (FU), result capture and SRF write-back.
//  Sits between the instruction dispatch and the SRF/FU pair of one slice.
// PARAMETERS
//  NUM_STREAM_ID        5   width of stream IDs; IDs wrap modulo 2**NUM_STREAM_ID
//  MIN_VEC_LENGTH       16  bits per tile element
//  NUM_TILES_PER_SLICE  20  elements per vector (unpacked dimension)
//  COUNT_WIDTH          6   width of iteration count
// PORTS
//  clk               in   1          clock, all state on rising edge
//  rst_n             in   1          asynchronous active-low reset
//  cmd_valid         in   1          command offered
//  cmd_ready         out  1          command accepted when valid&ready
//  cmd_src1/cmd_src2 in   NUM_STREAM_ID  first source stream IDs
//  cmd_dest          in   NUM_STREAM_ID  first destination stream ID
//  cmd_count         in   COUNT_WIDTH    number of iterations
//  busy              out  1          high from acceptance until DONE
//  done              out  1          one-cycle pulse when command completes
//  srf_read_enable   out  1          SRF read strobe
//  srf_write_enable  out  1          SRF write strobe
//  stream_src1/2     out  NUM_STREAM_ID  SRF read addresses
//  stream_dest       out  NUM_STREAM_ID  SRF write address
//  srf_data1/2       in   [MIN_VEC_LENGTH-1:0][0:NUM_TILES-1]  SRF read data (1-cycle latency)
//  write_data        out  same       SRF write data
//  op_valid/op_ready out/in 1        operand handshake to FU
//  op_data1/op_data2 out  same       operands (= srf_data1/2, held stable by SRF)
//  res_valid/res_ready in/out 1      result handshake from FU
//  res_data          in   same       FU result vector
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0 incl. write_data/addresses; counters 0.
//   Reset mid-command discards all progress; no SRF write may occur after rst_n falls.
//  States: IDLE -> READ -> ISSUE -> WAIT_RES -> WRITE -> (READ | DONE) ; DONE -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid: latch src1/src2/dest/count; count=0 -> DONE directly
//   (no SRF/FU activity); else -> READ. busy=1 in every state except IDLE.
//  READ: srf_read_enable=1 exactly one cycle with stream_src1/2 = current IDs -> ISSUE.
//  ISSUE: entered the cycle SRF data is valid; op_valid=1 held until op_valid&op_ready,
//   op_data must not change while op_valid=1 -> WAIT_RES.
//  WAIT_RES: res_ready=1; on res_valid capture res_data into write buffer -> WRITE.
//  WRITE: srf_write_enable=1 one cycle, stream_dest=current dest, write_data=buffer.
//   Then src1,src2,dest each +1 mod 2**NUM_STREAM_ID, remaining-1; remaining>0 -> READ else DONE.
//  DONE: done=1 one cycle, busy=1 -> IDLE (new command accepted no earlier than next cycle).
//  RAW: READ of iteration k+1 follows WRITE of k by one cycle, so dest==src is coherent.
//  Never assert srf_read_enable and srf_write_enable in same cycle.
//  Minimum latency per iteration: 4 cycles (READ,ISSUE,WAIT_RES,WRITE) with ready FU.
//  cmd_count = 2**COUNT_WIDTH-1 (63) legal; IDs wrap 31 -> 0.
// TESTING
//  1. src1=0,src2=4,dest=8,count=1, FU adds, always ready -> one read(0,4), write S8=sum
//     4 cycles after acceptance, done pulse next cycle, busy low after.
//  2. count=3, src1=30,src2=31,dest=29 -> reads (30,31),(31,0),(0,1); writes 29,30,31; wrap ok.
//  3. op_ready low 5 cycles, res_valid delayed 3 -> op_valid/op_data stable, no early write.
//  4. count=0 -> done pulse, zero srf_read/write_enable pulses, cmd_ready back next cycle.
//  5. dest==src1 chain count=2 (src1=2,dest=2) -> iteration 2 reads iteration 1's result.
//  6. rst_n low during WAIT_RES -> outputs 0 immediately, no write, next cmd runs normally.

Source files
------------

// File: rtl/srf_stream_sequencer_if.sv
// Command, SRF and FU handshake bundle for one SRF slice port.
interface srf_stream_sequencer_if #(
  parameter int unsigned NUM_STREAM_ID       = 5,
  parameter int unsigned MIN_VEC_LENGTH      = 16,
  parameter int unsigned NUM_TILES_PER_SLICE = 20,
  parameter int unsigned COUNT_WIDTH         = 6
);
  // Dispatch command channel
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [NUM_STREAM_ID-1:0]       cmd_src1;
  logic [NUM_STREAM_ID-1:0]       cmd_src2;
  logic [NUM_STREAM_ID-1:0]       cmd_dest;
  logic [COUNT_WIDTH-1:0]         cmd_count;
  logic                           busy;
  logic                           done;
  // SRF access
  logic                           srf_read_enable;
  logic                           srf_write_enable;
  logic [NUM_STREAM_ID-1:0]       stream_src1;
  logic [NUM_STREAM_ID-1:0]       stream_src2;
  logic [NUM_STREAM_ID-1:0]       stream_dest;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] srf_data1;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] srf_data2;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] write_data;
  // Functional unit handshakes
  logic                           op_valid;
  logic                           op_ready;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] op_data1;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] op_data2;
  logic                           res_valid;
  logic                           res_ready;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] res_data;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_src1, cmd_src2, cmd_dest, cmd_count,
    output cmd_ready, busy, done,
    output srf_read_enable, srf_write_enable, stream_src1, stream_src2, stream_dest, write_data,
    input  srf_data1, srf_data2,
    output op_valid, op_data1, op_data2,
    input  op_ready,
    input  res_valid, res_data,
    output res_ready
  );

  // Dispatch / SRF / FU side
  modport slave (
    output cmd_valid, cmd_src1, cmd_src2, cmd_dest, cmd_count,
    input  cmd_ready, busy, done,
    input  srf_read_enable, srf_write_enable, stream_src1, stream_src2, stream_dest, write_data,
    output srf_data1, srf_data2,
    input  op_valid, op_data1, op_data2,
    output op_ready,
    output res_valid, res_data,
    input  res_ready
  );
endinterface

// File: rtl/srf_stream_sequencer.sv
// SRF stream sequencer: per iteration reads two source streams, hands the operands
// to the FU, captures the result and writes it back to the destination stream.
module srf_stream_sequencer #(
  parameter int unsigned NUM_STREAM_ID       = 5,
  parameter int unsigned MIN_VEC_LENGTH      = 16,
  parameter int unsigned NUM_TILES_PER_SLICE = 20,
  parameter int unsigned COUNT_WIDTH         = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  srf_stream_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT_RES,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                         state_q;
  logic                           cmd_ready_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           srf_re_q;
  logic                           srf_we_q;
  logic                           op_valid_q;
  logic                           res_ready_q;
  logic [NUM_STREAM_ID-1:0]       src1_q;
  logic [NUM_STREAM_ID-1:0]       src2_q;
  logic [NUM_STREAM_ID-1:0]       dest_q;
  logic [COUNT_WIDTH-1:0]         remaining_q;
  logic [MIN_VEC_LENGTH-1:0][0:NUM_TILES_PER_SLICE-1] wbuf_q;

  // Sequencing FSM; every output is a register set on entry to the state that owns it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      srf_re_q    <= 1'b0;
      srf_we_q    <= 1'b0;
      op_valid_q  <= 1'b0;
      res_ready_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      dest_q      <= '0;
      remaining_q <= '0;
      wbuf_q      <= '0;
    end else begin
      srf_re_q <= 1'b0;
      srf_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            src1_q      <= bus.cmd_src1;
            src2_q      <= bus.cmd_src2;
            dest_q      <= bus.cmd_dest;
            remaining_q <= bus.cmd_count;
            if (bus.cmd_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_READ;
              srf_re_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q    <= S_ISSUE;
          op_valid_q <= 1'b1;
        end
        S_ISSUE: begin
          if (bus.op_ready) begin
            op_valid_q  <= 1'b0;
            res_ready_q <= 1'b1;
            state_q     <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (bus.res_valid) begin
            res_ready_q <= 1'b0;
            wbuf_q      <= bus.res_data;
            srf_we_q    <= 1'b1;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          src1_q      <= src1_q + NUM_STREAM_ID'(1);
          src2_q      <= src2_q + NUM_STREAM_ID'(1);
          dest_q      <= dest_q + NUM_STREAM_ID'(1);
          remaining_q <= remaining_q - COUNT_WIDTH'(1);
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= S_READ;
            srf_re_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output drive; operands are the SRF read data, which the SRF holds until the next read
  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.srf_read_enable  = srf_re_q;
  assign bus.srf_write_enable = srf_we_q;
  assign bus.stream_src1      = src1_q;
  assign bus.stream_src2      = src2_q;
  assign bus.stream_dest      = dest_q;
  assign bus.write_data       = wbuf_q;
  assign bus.op_valid         = op_valid_q;
  assign bus.op_data1         = bus.srf_data1;
  assign bus.op_data2         = bus.srf_data2;
  assign bus.res_ready        = res_ready_q;

endmodule

// File: tb/tb_srf_stream_sequencer.sv
// Bench for srf_stream_sequencer: SRF memory and adding FU models, queue-based reference.
module tb_srf_stream_sequencer;

  localparam int unsigned NID = 5;
  localparam int unsigned VL  = 16;
  localparam int unsigned NT  = 20;
  localparam int unsigned CW  = 6;
  localparam int unsigned VW  = VL * NT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  srf_stream_sequencer_if #(.NUM_STREAM_ID(NID), .MIN_VEC_LENGTH(VL),
                            .NUM_TILES_PER_SLICE(NT), .COUNT_WIDTH(CW)) ifc ();

  srf_stream_sequencer #(.NUM_STREAM_ID(NID), .MIN_VEC_LENGTH(VL),
                         .NUM_TILES_PER_SLICE(NT), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [VW-1:0] mem    [32];
  logic [VW-1:0] refmem [32];

  int            rlog   [$];
  int            wlog_a [$];
  logic [VW-1:0] wlog_d [$];

  int op_stall_cfg  = 0;
  int res_delay_cfg = 0;
  int stall_left    = 0;
  int res_fire_cnt  = 0;
  int wr_cnt        = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // SRF and FU environment, evaluated mid-cycle
  initial begin
    bit            pend;
    int            pend_cnt;
    logic [VW-1:0] pend_data, p_sum, p_d1, p_d2, a, b;
    bit            p_op_fire, p_op_valid, p_res_fire;
    pend = 0; pend_cnt = 0; pend_data = '0; p_sum = '0; p_d1 = '0; p_d2 = '0;
    p_op_fire = 0; p_op_valid = 0; p_res_fire = 0;
    ifc.srf_data1 = '0;
    ifc.srf_data2 = '0;
    ifc.op_ready  = 1'b1;
    ifc.res_valid = 1'b0;
    ifc.res_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ifc.res_valid = 1'b0;
        ifc.op_ready  = 1'b1;
        pend = 0; p_op_fire = 0; p_op_valid = 0; p_res_fire = 0;
        stall_left = op_stall_cfg;
      end else begin
        if (p_res_fire) begin
          ifc.res_valid = 1'b0;
          res_fire_cnt++;
        end
        if (p_op_fire) begin
          pend = 1; pend_cnt = res_delay_cfg; pend_data = p_sum;
          stall_left = op_stall_cfg;
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            ifc.res_valid = 1'b1;
            ifc.res_data  = pend_data;
            pend = 0;
          end else pend_cnt--;
        end
        chk("rd_wr_exclusive", VW'(ifc.srf_read_enable & ifc.srf_write_enable), VW'(0));
        if (ifc.srf_write_enable) begin
          wr_cnt++;
          chk("write_after_result", VW'(res_fire_cnt), VW'(wr_cnt));
          mem[ifc.stream_dest] = ifc.write_data;
          wlog_a.push_back(int'(ifc.stream_dest));
          wlog_d.push_back(ifc.write_data);
        end
        if (ifc.srf_read_enable) begin
          ifc.srf_data1 = mem[ifc.stream_src1];
          ifc.srf_data2 = mem[ifc.stream_src2];
          rlog.push_back(int'(ifc.stream_src1) * 32 + int'(ifc.stream_src2));
        end
        if (p_op_valid && !p_op_fire) begin
          chk("op_valid_hold", VW'(ifc.op_valid), VW'(1));
          chk("op_data1_hold", ifc.op_data1, p_d1);
          chk("op_data2_hold", ifc.op_data2, p_d2);
        end
        if (ifc.op_valid && stall_left > 0) begin
          ifc.op_ready = 1'b0;
          stall_left--;
        end else ifc.op_ready = 1'b1;
        a = ifc.op_data1;
        b = ifc.op_data2;
        p_op_fire  = ifc.op_valid && ifc.op_ready;
        p_op_valid = ifc.op_valid;
        p_sum      = a + b;
        p_d1       = a;
        p_d2       = b;
        p_res_fire = ifc.res_valid && ifc.res_ready;
      end
    end
  end

  // One command end to end, against a reference built from the stream rules
  task automatic run_cmd(input int s1, input int s2, input int d, input int cnt,
                         input int stall, input int rdly);
    int            exp_r  [$];
    int            exp_wa [$];
    logic [VW-1:0] exp_wd [$];
    logic [VW-1:0] v;
    int            cyc;
    bit            seen;
    for (int i = 0; i < cnt; i++) begin
      int ra, rb, wa;
      ra = (s1 + i) % 32;
      rb = (s2 + i) % 32;
      wa = (d + i) % 32;
      exp_r.push_back(ra * 32 + rb);
      v = refmem[ra] + refmem[rb];
      refmem[wa] = v;
      exp_wa.push_back(wa);
      exp_wd.push_back(v);
    end
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    res_fire_cnt = 0; wr_cnt = 0;
    op_stall_cfg = stall; stall_left = stall; res_delay_cfg = rdly;
    @(negedge clk);
    chk("cmd_ready_idle", VW'(ifc.cmd_ready), VW'(1));
    ifc.cmd_valid = 1'b1;
    ifc.cmd_src1  = NID'(s1);
    ifc.cmd_src2  = NID'(s2);
    ifc.cmd_dest  = NID'(d);
    ifc.cmd_count = CW'(cnt);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    chk("busy_after_accept", VW'(ifc.busy), VW'(1));
    cyc = 1; seen = 0;
    while (!seen && cyc < 5000) begin
      if (ifc.done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", VW'(seen), VW'(1));
    chk("done_latency", VW'(cyc), VW'(cnt * (4 + stall + rdly) + 1));
    chk("busy_at_done", VW'(ifc.busy), VW'(1));
    @(negedge clk);
    chk("done_one_cycle", VW'(ifc.done), VW'(0));
    chk("busy_idle", VW'(ifc.busy), VW'(0));
    chk("cmd_ready_back", VW'(ifc.cmd_ready), VW'(1));
    chk("num_reads", VW'(rlog.size()), VW'(exp_r.size()));
    chk("num_writes", VW'(wlog_a.size()), VW'(exp_wa.size()));
    for (int i = 0; i < exp_r.size() && i < rlog.size(); i++)
      chk("read_ids", VW'(rlog[i]), VW'(exp_r[i]));
    for (int i = 0; i < exp_wa.size() && i < wlog_a.size(); i++) begin
      chk("write_dest", VW'(wlog_a[i]), VW'(exp_wa[i]));
      chk("write_data", wlog_d[i], exp_wd[i]);
    end
  endtask

  initial begin
    logic [VW-1:0] v;
    int            cyc;
    for (int i = 0; i < 32; i++) begin
      for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
      mem[i]    = v;
      refmem[i] = v;
    end
    ifc.cmd_valid = 1'b0;
    ifc.cmd_src1  = '0;
    ifc.cmd_src2  = '0;
    ifc.cmd_dest  = '0;
    ifc.cmd_count = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", VW'(ifc.cmd_ready), VW'(0));
    chk("rst_busy", VW'(ifc.busy), VW'(0));
    chk("rst_done", VW'(ifc.done), VW'(0));
    chk("rst_read_en", VW'(ifc.srf_read_enable), VW'(0));
    chk("rst_write_en", VW'(ifc.srf_write_enable), VW'(0));
    chk("rst_op_valid", VW'(ifc.op_valid), VW'(0));
    chk("rst_res_ready", VW'(ifc.res_ready), VW'(0));
    chk("rst_src1", VW'(ifc.stream_src1), VW'(0));
    chk("rst_dest", VW'(ifc.stream_dest), VW'(0));
    chk("rst_write_data", ifc.write_data, VW'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(0, 4, 8, 1, 0, 0);
    run_cmd(30, 31, 29, 3, 0, 0);
    run_cmd(5, 6, 7, 2, 5, 3);
    run_cmd(9, 10, 11, 0, 0, 0);
    run_cmd(2, 12, 2, 2, 0, 0);
    run_cmd(2, 12, 3, 2, 0, 0);

    // Reset while waiting for a result: progress discarded, nothing written
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    op_stall_cfg = 0; stall_left = 0; res_delay_cfg = 20;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_src1  = NID'(1);
    ifc.cmd_src2  = NID'(2);
    ifc.cmd_dest  = NID'(3);
    ifc.cmd_count = CW'(2);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    cyc = 0;
    while (!ifc.res_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_wait_res", VW'(ifc.res_ready), VW'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", VW'(ifc.busy), VW'(0));
    chk("midrst_res_ready", VW'(ifc.res_ready), VW'(0));
    chk("midrst_write_en", VW'(ifc.srf_write_enable), VW'(0));
    chk("midrst_src1", VW'(ifc.stream_src1), VW'(0));
    chk("midrst_dest", VW'(ifc.stream_dest), VW'(0));
    chk("midrst_cmd_ready", VW'(ifc.cmd_ready), VW'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    res_delay_cfg = 0;
    repeat (5) @(negedge clk);
    chk("no_write_after_reset", VW'(wlog_a.size()), VW'(0));
    run_cmd(3, 4, 5, 1, 0, 0);

    for (int t = 0; t < 8; t++)
      run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(1, 6)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), 63, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
